// File: rtl/freq_div_sequencer_if.sv
// Host-side command handshake and divider-side control bundle for freq_div_sequencer.
// The master modport is the host/testbench view. The slave modport is the sequencer view.
interface freq_div_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_div;
    logic [WIDTH-1:0] cmd_run_len;
    logic             stop;
    logic [WIDTH-1:0] din;
    logic             config_div;
    logic             enable;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid,
        output cmd_div,
        output cmd_run_len,
        output stop,
        input  cmd_ready,
        input  din,
        input  config_div,
        input  enable,
        input  busy,
        input  done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_div,
        input  cmd_run_len,
        input  stop,
        output cmd_ready,
        output din,
        output config_div,
        output enable,
        output busy,
        output done
    );
endinterface

// File: rtl/freq_div_sequencer.sv
// Loads a divide ratio into the downstream divider while it is disabled, runs it for a
// commanded number of cycles (or until stopped), then drops enable and pulses done.
module freq_div_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input logic                 clk,
    input logic                 rst,
    freq_div_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun
    } state_e;

    localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic [WIDTH-1:0] run_len_q, run_len_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             config_div_q, config_div_d;
    logic             enable_q, enable_d;
    logic             done_q, done_d;

    logic cmd_ready;
    logic cmd_accept;
    logic expired;

    // Held low during reset and through LOAD so a command is never taken mid-configure.
    assign cmd_ready  = !rst && (state_q != StLoad) && !bus.stop;
    assign cmd_accept = bus.cmd_valid && cmd_ready;
    assign expired    = (run_len_q != '0) && (cnt_q == run_len_q);

    always_comb begin
        state_d   = state_q;
        din_d     = din_q;
        run_len_d = run_len_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;

        if (cmd_accept) begin
            din_d     = (bus.cmd_div == '0) ? One : bus.cmd_div;
            run_len_d = bus.cmd_run_len;
        end

        unique case (state_q)
            StIdle: begin
                if (cmd_accept) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                if (bus.stop) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = StRun;
                    cnt_d   = One;
                end
            end
            StRun: begin
                // A command on the expiry edge retargets rather than finishing.
                if (bus.stop) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else if (cmd_accept) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end else if (expired) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + One;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        config_div_d = (state_d == StLoad);
        enable_d     = (state_d == StRun);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            din_q        <= One;
            run_len_q    <= '0;
            cnt_q        <= '0;
            config_div_q <= 1'b0;
            enable_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            din_q        <= din_d;
            run_len_q    <= run_len_d;
            cnt_q        <= cnt_d;
            config_div_q <= config_div_d;
            enable_q     <= enable_d;
            done_q       <= done_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.din        = din_q;
    assign bus.config_div = config_div_q;
    assign bus.enable     = enable_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_freq_div_sequencer.sv
// Directed bench for freq_div_sequencer: a countdown-based reference model checked every
// cycle, plus hand-computed window counts that pin the model for each scenario.
module tb_freq_div_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    freq_div_sequencer_if #(.WIDTH(32)) bus ();

    freq_div_sequencer #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected registered outputs for the cycle after each edge.
    logic        e_cfg = 1'b0;
    logic        e_en = 1'b0;
    logic        e_done = 1'b0;
    logic [31:0] e_din = 32'd1;
    logic [31:0] m_len = 32'd0;
    logic [31:0] e_left = 32'd0;
    logic        e_inf = 1'b0;
    logic        acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_cfg  = 1'b0;
            e_en   = 1'b0;
            e_done = 1'b0;
            e_din  = 32'd1;
            m_len  = 32'd0;
            e_left = 32'd0;
            e_inf  = 1'b0;
        end else begin
            acc    = bus.cmd_valid && !bus.stop && !e_cfg;
            e_done = 1'b0;
            if (e_cfg) begin
                e_cfg = 1'b0;
                if (bus.stop) begin
                    e_done = 1'b1;
                end else begin
                    e_en   = 1'b1;
                    e_inf  = (m_len == 0);
                    e_left = m_len;
                end
            end else if (e_en) begin
                if (bus.stop) begin
                    e_en   = 1'b0;
                    e_done = 1'b1;
                end else if (acc) begin
                    e_en  = 1'b0;
                    e_cfg = 1'b1;
                end else if (!e_inf && e_left == 1) begin
                    e_en   = 1'b0;
                    e_done = 1'b1;
                end else if (!e_inf) begin
                    e_left = e_left - 1;
                end
            end else if (acc) begin
                e_cfg = 1'b1;
            end
            if (acc) begin
                e_din = (bus.cmd_div == 0) ? 32'd1 : bus.cmd_div;
                m_len = bus.cmd_run_len;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("cmd_ready", {31'd0, bus.cmd_ready}, {31'd0, !rst && !bus.stop && !e_cfg});
        chk("din", bus.din, e_din);
        chk("config_div", {31'd0, bus.config_div}, {31'd0, e_cfg});
        chk("enable", {31'd0, bus.enable}, {31'd0, e_en});
        chk("done", {31'd0, bus.done}, {31'd0, e_done});
        chk("busy", {31'd0, bus.busy}, {31'd0, e_cfg || e_en});
        chk("cfg_en_overlap", {31'd0, bus.config_div && bus.enable}, 32'd0);
    end

    // Window observation: one sample per cycle, 1 time unit after the edge.
    int          n_en, n_cfg, n_busy, n_done;
    logic [31:0] din_cfg;
    logic        s_en[32];
    logic        s_done[32];
    logic        s_busy[32];

    task automatic observe(input int n);
        n_en    = 0;
        n_cfg   = 0;
        n_busy  = 0;
        n_done  = 0;
        din_cfg = 32'hdead_beef;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            s_en[i]   = bus.enable;
            s_done[i] = bus.done;
            s_busy[i] = bus.busy;
            if (bus.enable) n_en++;
            if (bus.config_div) begin
                n_cfg++;
                din_cfg = bus.din;
            end
            if (bus.busy) n_busy++;
            if (bus.done) n_done++;
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            bus.stop      = 1'b0;
        end
    endtask

    task automatic send(input logic [31:0] div, input logic [31:0] len);
        bus.cmd_valid   = 1'b1;
        bus.cmd_div     = div;
        bus.cmd_run_len = len;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid   = 1'b0;
        bus.cmd_div     = 32'd0;
        bus.cmd_run_len = 32'd0;
        bus.stop        = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_din", bus.din, 32'd1);
        chk("rst_enable", {31'd0, bus.enable}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic 4 / 10 run.
        send(32'd4, 32'd10);
        observe(14);
        chk("t1_cfg_cycles", n_cfg, 1);
        chk("t1_din_load", din_cfg, 32'd4);
        chk("t1_en_cycles", n_en, 10);
        chk("t1_busy_cycles", n_busy, 11);
        chk("t1_done_cycles", n_done, 1);
        chk("t1_done_pos", {31'd0, s_done[11]}, 32'd1);

        // Zero ratio clamps to one.
        send(32'd0, 32'd3);
        observe(8);
        chk("t2_din_load", din_cfg, 32'd1);
        chk("t2_en_cycles", n_en, 3);
        chk("t2_done_cycles", n_done, 1);

        // Unbounded run, stop after 20 enabled cycles.
        send(32'd5, 32'd0);
        observe(21);
        chk("t3_en_cycles", n_en, 20);
        bus.stop = 1'b1;
        #1;
        chk("t3_ready_stop", {31'd0, bus.cmd_ready}, 32'd0);
        observe(3);
        chk("t3_en_after", {31'd0, s_en[0]}, 32'd0);
        chk("t3_done_after", {31'd0, s_done[0]}, 32'd1);
        chk("t3_busy_after", {31'd0, s_busy[0]}, 32'd0);
        chk("t3_done_once", n_done, 1);

        // Retarget from 8 to 2 mid-run.
        send(32'd8, 32'd0);
        observe(5);
        chk("t4_en_first", n_en, 4);
        send(32'd2, 32'd3);
        observe(6);
        chk("t4_load_en", {31'd0, s_en[0]}, 32'd0);
        chk("t4_load_done", {31'd0, s_done[0]}, 32'd0);
        chk("t4_din_load", din_cfg, 32'd2);
        chk("t4_en_back", {31'd0, s_en[1]}, 32'd1);
        chk("t4_en_cycles", n_en, 3);
        chk("t4_done_pos", {31'd0, s_done[4]}, 32'd1);

        // Stop and command together in RUN.
        send(32'd3, 32'd0);
        observe(3);
        bus.stop = 1'b1;
        send(32'd7, 32'd5);
        #1;
        chk("t5_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
        observe(4);
        chk("t5_done", {31'd0, s_done[0]}, 32'd1);
        chk("t5_no_load", n_cfg, 0);
        chk("t5_no_en", n_en, 0);

        // Stop during LOAD.
        send(32'd6, 32'd4);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.stop      = 1'b1;
        observe(4);
        chk("t6_no_en", n_en, 0);
        chk("t6_done", {31'd0, s_done[0]}, 32'd1);
        chk("t6_busy", n_busy, 0);

        // Asynchronous reset mid-run, then a normal command.
        send(32'd9, 32'd0);
        observe(4);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_enable", {31'd0, bus.enable}, 32'd0);
        chk("t7_cfg", {31'd0, bus.config_div}, 32'd0);
        chk("t7_done", {31'd0, bus.done}, 32'd0);
        chk("t7_busy", {31'd0, bus.busy}, 32'd0);
        chk("t7_din", bus.din, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(32'd4, 32'd2);
        observe(6);
        chk("t7_din_load", din_cfg, 32'd4);
        chk("t7_en_cycles", n_en, 2);
        chk("t7_done_cycles", n_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
